// File: rtl/datapath_rr_sequencer_if.sv
// Request/response bundle for datapath_rr_sequencer.
// master: request sources and response sink.  slave: the sequencer.
interface datapath_rr_sequencer_if #(
    parameter int NUM_REQ = 4,
    parameter int DIN_W   = 7,
    parameter int DOUT_W  = 9
) ();
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*DIN_W-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [DOUT_W-1:0]        rsp_data;
    logic [ID_W-1:0]          rsp_id;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/datapath_rr_sequencer.sv
// datapath_rr_sequencer: shares one combinational datapath between NUM_REQ
// requesters with round-robin arbitration. The operand is registered, the
// result is captured DP_LATENCY edges later and returned tagged with the
// requester index.
// Optional macro DP_SEQ_STATS_EN adds saturating transaction/stall counters.
//
// state | meaning
// IDLE  | arbitrating; req_ready offered to the round-robin winner
// WAIT  | operand held on the datapath, counting down the settle latency
// RESP  | result held on the response channel until rsp_ready
module datapath_rr_sequencer #(
    parameter int NUM_REQ    = 4,
    parameter int DIN_W      = 7,
    parameter int DOUT_W     = 9,
    parameter int DP_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    datapath_rr_sequencer_if.slave bus,
    output logic [DIN_W-1:0]       dp_input_data,
    input  logic [DOUT_W-1:0]      dp_output_data,
    output logic                   busy
`ifdef DP_SEQ_STATS_EN
    ,
    output logic [15:0]            stat_txn_count,
    output logic [15:0]            stat_stall_count
`endif
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   last_ptr;
    logic [3:0]        wait_cnt;
    logic              grant_vld;
    logic [ID_W-1:0]   grant_idx;
    logic [DIN_W-1:0]  grant_data;

    // Round-robin search starting just after the last granted requester.
    // Walking offsets from far to near lets the nearest valid one win.
    always_comb begin : arb
        int idx;
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        idx        = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last_ptr) + k) % NUM_REQ;
            if (bus.req_valid[ID_W'(idx)]) begin
                grant_vld = 1'b1;
                grant_idx = ID_W'(idx);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i))
                grant_data = bus.req_data[i*DIN_W +: DIN_W];
        end
    end

    // Accept is offered only in IDLE; held low while reset is asserted.
    assign bus.req_ready = (rst_n && state == IDLE && grant_vld) ?
                           (NUM_REQ'(1) << grant_idx) : '0;

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_ptr      <= ID_W'(NUM_REQ - 1);
            wait_cnt      <= '0;
            dp_input_data <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_id    <= '0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        dp_input_data <= grant_data;
                        bus.rsp_id    <= grant_idx;
                        last_ptr      <= grant_idx;
                        wait_cnt      <= 4'(DP_LATENCY);
                        state         <= WAIT;
                        busy          <= 1'b1;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        bus.rsp_data  <= dp_output_data;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                        busy          <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DP_SEQ_STATS_EN
    // Saturating count of completed response handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stat_txn_count <= '0;
        else if (bus.rsp_valid && bus.rsp_ready && stat_txn_count != 16'hFFFF)
            stat_txn_count <= stat_txn_count + 16'd1;
    end

    // Saturating count of cycles the response sink applied backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stat_stall_count <= '0;
        else if (bus.rsp_valid && !bus.rsp_ready && stat_stall_count != 16'hFFFF)
            stat_stall_count <= stat_stall_count + 16'd1;
    end
`endif
endmodule
